// File: rtl/polyphase_pkg.sv
// Shared types and constants for the polyphase capture sequencer and its buffer.
package polyphase_pkg;

   typedef enum logic [2:0] {IDLE, ALIGN, FLUSH, CAPTURE, DRAIN} state_t;

   localparam logic [1:0] PH_LAST = 2'd3;

   function automatic int lane_word_w(input int bw);
      return 4 * bw;
   endfunction

endpackage

// File: rtl/polyphase_capture_fifo.sv
// Word buffer with registered head output: a push at cycle t is visible at t+1,
// and the head register holds its last value once the buffer drains.
module polyphase_capture_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             valid,
   output logic             single
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic [AW:0]      wr_ptr_next;
   logic [AW:0]      rd_ptr_next;
   logic [AW:0]      level;
   logic [WIDTH-1:0] data_reg;
   logic             push_ok;
   logic             pop_ok;

   assign valid       = (wr_ptr_reg != rd_ptr_reg);
   assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign level       = wr_ptr_reg - rd_ptr_reg;
   assign single      = (level == (AW+1)'(1));
   assign pop_ok      = pop & valid;
   // A pop in the same cycle frees the slot, so a push into a full buffer is legal.
   assign push_ok     = push & (~full | pop_ok);
   assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
   assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
   assign pop_data    = data_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (srst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end

      if (srst) begin
         data_reg <= '0;
      end else if (!flush && (wr_ptr_next != rd_ptr_next)) begin
         // Bypass when the new head is the word being written this cycle.
         if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            data_reg <= push_data;
         end else begin
            data_reg <= mem[rd_ptr_next[AW-1:0]];
         end
      end
   end

endmodule

// File: rtl/polyphase_capture_ctrl.sv
// Capture sequencer for the 4-path polyphase demux: phase strobes, ENABLE,
// pipeline flush, word collection and valid/ready readout.
module polyphase_capture_ctrl
   import polyphase_pkg::*;
#(
   parameter int BW       = 6,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 10,
   parameter int PIPE_LAT = 2
) (
   input  logic                        CLK,
   input  logic                        RES,
   input  logic                        START,
   input  logic                        ABORT,
   input  logic [CNT_W-1:0]            NUM_WORDS,
   input  logic [BW-1:0]               IN1,
   input  logic [BW-1:0]               IN2,
   input  logic [BW-1:0]               IN3,
   input  logic [BW-1:0]               IN4,
   output logic                        ENABLE,
   output logic                        CE2,
   output logic                        CE4,
   output logic [lane_word_w(BW)-1:0]  RD_DATA,
   output logic                        RD_VALID,
   input  logic                        RD_READY,
   output logic                        BUSY,
   output logic                        DONE,
   output logic                        OVERFLOW
);

   localparam int WORD_W = lane_word_w(BW);
   localparam int FL_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   state_t           state_reg;
   logic [1:0]       ph_reg;
   logic             enable_reg;
   logic             done_reg;
   logic             overflow_reg;
   logic [CNT_W-1:0] cnt_cfg_reg;
   logic [CNT_W-1:0] word_cnt_reg;
   logic [CNT_W-1:0] word_inc;
   logic [FL_W-1:0]  flush_cnt_reg;
   logic             ce4;
   logic             pop;
   logic             push;
   logic             fifo_full;
   logic             fifo_single;

   assign ce4      = (ph_reg == PH_LAST);
   assign CE2      = ph_reg[0];
   assign CE4      = ce4;
   assign ENABLE   = enable_reg;
   assign DONE     = done_reg;
   assign OVERFLOW = overflow_reg;
   assign BUSY     = (state_reg != IDLE);
   assign pop      = RD_VALID & RD_READY;
   assign push     = ce4 && (state_reg == CAPTURE);
   assign word_inc = word_cnt_reg + CNT_W'(1);

   polyphase_capture_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk       (CLK),
      .srst      (RES),
      .flush     (ABORT),
      .push      (push),
      .push_data ({IN4, IN3, IN2, IN1}),
      .full      (fifo_full),
      .pop       (RD_READY),
      .pop_data  (RD_DATA),
      .valid     (RD_VALID),
      .single    (fifo_single)
   );

   always_ff @(posedge CLK) begin
      if (RES) begin
         ph_reg        <= 2'd0;
         state_reg     <= IDLE;
         enable_reg    <= 1'b0;
         done_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
         cnt_cfg_reg   <= '0;
         word_cnt_reg  <= '0;
         flush_cnt_reg <= '0;
      end else begin
         ph_reg   <= ph_reg + 2'd1;
         done_reg <= 1'b0;
         if (ABORT) begin
            state_reg     <= IDLE;
            enable_reg    <= 1'b0;
            word_cnt_reg  <= '0;
            flush_cnt_reg <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (START) begin
                     cnt_cfg_reg  <= NUM_WORDS;
                     overflow_reg <= 1'b0;
                     if (NUM_WORDS == '0) begin
                        done_reg <= 1'b1;
                     end else begin
                        state_reg <= ALIGN;
                     end
                  end
               end
               ALIGN: begin
                  if (ce4) begin
                     enable_reg <= 1'b1;
                     state_reg  <= (PIPE_LAT == 0) ? CAPTURE : FLUSH;
                  end
               end
               FLUSH: begin
                  if (ce4) begin
                     if (flush_cnt_reg == FL_W'(PIPE_LAT - 1)) begin
                        flush_cnt_reg <= '0;
                        state_reg     <= CAPTURE;
                     end else begin
                        flush_cnt_reg <= flush_cnt_reg + FL_W'(1);
                     end
                  end
               end
               CAPTURE: begin
                  if (ce4) begin
                     if (fifo_full && !pop) begin
                        overflow_reg <= 1'b1;
                     end
                     // Dropped words still count toward the programmed total.
                     if (word_inc == cnt_cfg_reg) begin
                        word_cnt_reg <= '0;
                        enable_reg   <= 1'b0;
                        state_reg    <= DRAIN;
                     end else begin
                        word_cnt_reg <= word_inc;
                     end
                  end
               end
               DRAIN: begin
                  if (!RD_VALID || (pop && fifo_single)) begin
                     done_reg  <= 1'b1;
                     state_reg <= IDLE;
                  end
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_polyphase_capture_ctrl.sv
// Directed bench: lanes carry a tag derived from the cycle count since reset,
// so every expected readout word and event cycle is a hand-computed constant.
module tb_polyphase_capture_ctrl;

   localparam int BW       = 6;
   localparam int DEPTH    = 8;
   localparam int CNT_W    = 10;
   localparam int PIPE_LAT = 2;
   localparam int WW       = 4 * BW;

   logic             CLK = 1'b0;
   logic             RES;
   logic             START;
   logic             ABORT;
   logic [CNT_W-1:0] NUM_WORDS;
   logic [BW-1:0]    IN1, IN2, IN3, IN4;
   logic             ENABLE, CE2, CE4, RD_VALID, RD_READY, BUSY, DONE, OVERFLOW;
   logic [WW-1:0]    RD_DATA;

   polyphase_capture_ctrl #(
      .BW       (BW),
      .DEPTH    (DEPTH),
      .CNT_W    (CNT_W),
      .PIPE_LAT (PIPE_LAT)
   ) dut (
      .CLK       (CLK),
      .RES       (RES),
      .START     (START),
      .ABORT     (ABORT),
      .NUM_WORDS (NUM_WORDS),
      .IN1       (IN1),
      .IN2       (IN2),
      .IN3       (IN3),
      .IN4       (IN4),
      .ENABLE    (ENABLE),
      .CE2       (CE2),
      .CE4       (CE4),
      .RD_DATA   (RD_DATA),
      .RD_VALID  (RD_VALID),
      .RD_READY  (RD_READY),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .OVERFLOW  (OVERFLOW)
   );

   always #5 CLK = ~CLK;

   int            cyc;
   int            n_checks;
   int            n_pass;
   int            n_fail;
   int            done_cnt;
   int            done_cyc;
   int            en_rise;
   int            en_cycles;
   logic [WW-1:0] rd_q[$];

   function automatic logic [BW-1:0] lane_val(input int tag, input int lane);
      return BW'((tag % 16) * 4 + lane);
   endfunction

   function automatic logic [WW-1:0] word_of(input int tag);
      return {lane_val(tag, 3), lane_val(tag, 2), lane_val(tag, 1), lane_val(tag, 0)};
   endfunction

   function automatic logic [31:0] q_at(input int k);
      if (k < rd_q.size()) return 32'(rd_q[k]);
      return 'x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_lanes();
      IN1 = lane_val(cyc / 4, 0);
      IN2 = lane_val(cyc / 4, 1);
      IN3 = lane_val(cyc / 4, 2);
      IN4 = lane_val(cyc / 4, 3);
   endtask

   task automatic tick();
      if (RD_VALID === 1'b1 && RD_READY === 1'b1) rd_q.push_back(RD_DATA);
      @(posedge CLK);
      #1;
      cyc++;
      drive_lanes();
      if (DONE === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (ENABLE === 1'b1) begin
         en_cycles++;
         if (en_rise < 0) en_rise = cyc;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic do_reset();
      RES   = 1'b1;
      START = 1'b0;
      ABORT = 1'b0;
      @(posedge CLK);
      #1;
      RES = 1'b0;
      cyc = 0;
      rd_q.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      en_rise   = -1;
      en_cycles = 0;
      drive_lanes();
   endtask

   task automatic start(input int n);
      START     = 1'b1;
      NUM_WORDS = CNT_W'(n);
      tick();
      START = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_enable"}, 32'(ENABLE), 0);
      chk({tag, "_ce2"}, 32'(CE2), 0);
      chk({tag, "_ce4"}, 32'(CE4), 0);
      chk({tag, "_rd_valid"}, 32'(RD_VALID), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_overflow"}, 32'(OVERFLOW), 0);
      chk({tag, "_rd_data"}, 32'(RD_DATA), 0);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      n_fail    = 0;
      cyc       = 0;
      RES       = 1'b1;
      START     = 1'b0;
      ABORT     = 1'b0;
      RD_READY  = 1'b0;
      NUM_WORDS = '0;
      drive_lanes();

      // Reset state and phase strobe start-up
      do_reset();
      chk_all_zero("reset");
      tick();
      chk("ph1_ce2", 32'(CE2), 1);
      chk("ph1_ce4", 32'(CE4), 0);
      run_to(3);
      chk("ph3_ce4", 32'(CE4), 1);

      // Basic capture: 3 words, PIPE_LAT=2, consumer always ready
      RD_READY = 1'b1;
      run_to(4);
      start(3);
      run_to(40);
      chk("t1_enable_rise", en_rise, 8);
      chk("t1_enable_cycles", en_cycles, 20);
      chk("t1_reads", rd_q.size(), 3);
      chk("t1_word0", q_at(0), 32'(word_of(4)));
      chk("t1_word1", q_at(1), 32'(word_of(5)));
      chk("t1_word2", q_at(2), 32'(word_of(6)));
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_cyc", done_cyc, 29);
      chk("t1_busy_end", 32'(BUSY), 0);

      // Overflow: 12 words into an 8-deep buffer with no consumer
      do_reset();
      RD_READY = 1'b0;
      run_to(4);
      start(12);
      run_to(51);
      chk("t2_ovf_before", 32'(OVERFLOW), 0);
      tick();
      chk("t2_ovf_after", 32'(OVERFLOW), 1);
      run_to(60);
      chk("t2_head_hold", 32'(RD_DATA), 32'(word_of(4)));
      chk("t2_valid_hold", 32'(RD_VALID), 1);
      run_to(70);
      chk("t2_head_stable", 32'(RD_DATA), 32'(word_of(4)));
      chk("t2_busy_drain", 32'(BUSY), 1);
      chk("t2_enable_drain", 32'(ENABLE), 0);
      chk("t2_no_reads", rd_q.size(), 0);
      RD_READY = 1'b1;
      run_to(85);
      chk("t2_reads", rd_q.size(), 8);
      chk("t2_word0", q_at(0), 32'(word_of(4)));
      chk("t2_word7", q_at(7), 32'(word_of(11)));
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_done_cyc", done_cyc, 78);
      chk("t2_ovf_sticky", 32'(OVERFLOW), 1);

      // Full buffer with a pop on the same CE4 cycle: no loss
      do_reset();
      RD_READY = 1'b0;
      run_to(4);
      start(9);
      run_to(51);
      RD_READY = 1'b1;
      run_to(70);
      chk("t3_ovf", 32'(OVERFLOW), 0);
      chk("t3_reads", rd_q.size(), 9);
      chk("t3_word0", q_at(0), 32'(word_of(4)));
      chk("t3_word8", q_at(8), 32'(word_of(12)));
      chk("t3_done_cyc", done_cyc, 60);

      // ABORT after 2 of 5 words, then a 1-word capture
      do_reset();
      RD_READY = 1'b0;
      run_to(4);
      start(5);
      run_to(25);
      chk("t4_valid_pre", 32'(RD_VALID), 1);
      chk("t4_enable_pre", 32'(ENABLE), 1);
      chk("t4_busy_pre", 32'(BUSY), 1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("t4_busy_post", 32'(BUSY), 0);
      chk("t4_enable_post", 32'(ENABLE), 0);
      chk("t4_valid_post", 32'(RD_VALID), 0);
      chk("t4_done_post", 32'(DONE), 0);
      RD_READY = 1'b1;
      run_to(36);
      chk("t4_no_done", done_cnt, 0);
      start(1);
      run_to(60);
      chk("t4_reads", rd_q.size(), 1);
      chk("t4_word0", q_at(0), 32'(word_of(12)));
      chk("t4_done_cnt", done_cnt, 1);
      chk("t4_done_cyc", done_cyc, 53);

      // NUM_WORDS=0, then a START while busy that must be ignored
      do_reset();
      RD_READY = 1'b1;
      run_to(4);
      start(0);
      chk("t5_zero_done", 32'(DONE), 1);
      chk("t5_zero_busy", 32'(BUSY), 0);
      run_to(12);
      chk("t5_zero_done_cnt", done_cnt, 1);
      chk("t5_zero_no_enable", en_cycles, 0);
      start(2);
      run_to(20);
      START     = 1'b1;
      NUM_WORDS = CNT_W'(7);
      tick();
      START = 1'b0;
      run_to(45);
      chk("t5_reads", rd_q.size(), 2);
      chk("t5_word0", q_at(0), 32'(word_of(6)));
      chk("t5_word1", q_at(1), 32'(word_of(7)));
      chk("t5_done_cnt", done_cnt, 2);
      chk("t5_done_cyc", done_cyc, 33);
      chk("t5_enable_cycles", en_cycles, 16);

      // RES mid-DRAIN with OVERFLOW set
      do_reset();
      RD_READY = 1'b0;
      run_to(4);
      start(12);
      run_to(70);
      chk("t6_ovf_pre", 32'(OVERFLOW), 1);
      chk("t6_busy_pre", 32'(BUSY), 1);
      chk("t6_valid_pre", 32'(RD_VALID), 1);
      do_reset();
      chk_all_zero("t6_reset");
      tick();
      chk("t6_ph1_ce2", 32'(CE2), 1);
      chk("t6_ph1_ce4", 32'(CE4), 0);
      tick();
      chk("t6_ph2_ce4", 32'(CE4), 0);
      tick();
      chk("t6_ph3_ce4", 32'(CE4), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
